// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: FSM state encoding and BCD limits.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// One BCD decade of the count chain.
//   clock, reset_n : clock and asynchronous active-low reset
//   clear_sync     : synchronous return to zero
//   inc            : advance this digit by one (9 rolls over to 0)
//   value          : current digit, always 0..9
//   carry          : value is 9, so the next increment rolls over
module bcd_digit
   import stopwatch_pkg::*;
(
   input  logic       clock,
   input  logic       reset_n,
   input  logic       clear_sync,
   input  logic       inc,
   output logic [3:0] value,
   output logic       carry
);

   // Digit register; anything at or above 9 rolls back to 0
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         value <= 4'd0;
      end else if (clear_sync) begin
         value <= 4'd0;
      end else if (inc) begin
         value <= (value >= BCD_MAX) ? 4'd0 : value + 4'd1;
      end
   end

   assign carry = (value == BCD_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Start/stop/lap/clear stopwatch sequencer over a cascaded BCD counter chain.
//   clock, reset_n   : clock and asynchronous active-low reset
//   start_stop       : pulse, toggles run/pause (highest priority)
//   clear            : pulse, returns to zero from PAUSE
//   lap              : pulse, toggles lap hold (lowest priority)
//   display          : lap snapshot while held, else live count; digit 0 in LSBs
//   running          : in RUN
//   lap_held         : display shows the lap snapshot
//   overflow         : sticky, count wrapped from all 9s
//   tick             : one-cycle prescaler pulse
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int unsigned TICK_DIV = 100000,
   parameter int unsigned DIGITS   = 4
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  start_stop,
   input  logic                  lap,
   input  logic                  clear,
   output logic [4*DIGITS-1:0]   display,
   output logic                  running,
   output logic                  lap_held,
   output logic                  overflow,
   output logic                  tick
);

   localparam int unsigned PW = $clog2(TICK_DIV);
   localparam int unsigned CW = 4 * DIGITS;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   state_t          state, state_nx;
   logic [PW-1:0]   presc, presc_nx;
   logic [CW-1:0]   count;
   logic [CW-1:0]   lap_reg, lap_nx;
   logic            lap_held_nx;
   logic            overflow_nx;
   logic            tick_nx;
   logic            clear_sync_c;
   logic            all_nine_c;
   logic [DIGITS-1:0] carry_c;
   logic [DIGITS-1:0] inc_c;

   // Digit chain: digit k advances on tick when every lower digit is 9
   for (genvar g = 0; g < DIGITS; g++) begin : g_dig
      if (g == 0) begin : g_lsd
         assign inc_c[g] = tick;
      end else begin : g_upper
         assign inc_c[g] = inc_c[g-1] & carry_c[g-1];
      end

      bcd_digit u_digit (
         .clock      (clock),
         .reset_n    (reset_n),
         .clear_sync (clear_sync_c),
         .inc        (inc_c[g]),
         .value      (count[4*g +: 4]),
         .carry      (carry_c[g])
      );
   end

   assign all_nine_c = &carry_c;

   // Next-state, prescaler and lap decisions; one button acted on per cycle
   always_comb begin
      state_nx     = state;
      presc_nx     = presc;
      lap_nx       = lap_reg;
      lap_held_nx  = lap_held;
      overflow_nx  = overflow;
      clear_sync_c = 1'b0;

      if (tick && all_nine_c) begin
         overflow_nx = 1'b1;
      end

      case (state)
         IDLE: begin
            presc_nx = '0;
            if (start_stop) begin
               state_nx = RUN;
            end
         end
         RUN: begin
            presc_nx = (presc == PRESC_LAST) ? '0 : presc + PW'(1);
            if (start_stop) begin
               state_nx = PAUSE;
            end else if (!clear && lap) begin
               // Capture uses the pre-increment count even on a tick cycle
               if (!lap_held) begin
                  lap_nx      = count;
                  lap_held_nx = 1'b1;
               end else begin
                  lap_held_nx = 1'b0;
               end
            end
         end
         PAUSE: begin
            if (start_stop) begin
               state_nx = RUN;
            end else if (clear) begin
               state_nx     = IDLE;
               presc_nx     = '0;
               lap_nx       = '0;
               lap_held_nx  = 1'b0;
               overflow_nx  = 1'b0;
               clear_sync_c = 1'b1;
            end else if (lap) begin
               lap_held_nx = 1'b0;
            end
         end
         default: begin
            state_nx = IDLE;
            presc_nx = '0;
         end
      endcase

      // tick is high exactly in the RUN cycles where the prescaler sits at its last value
      tick_nx = (state_nx == RUN) && (presc_nx == PRESC_LAST);
   end

   // State and registered outputs
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         presc    <= '0;
         lap_reg  <= '0;
         lap_held <= 1'b0;
         overflow <= 1'b0;
         tick     <= 1'b0;
         running  <= 1'b0;
      end else begin
         state    <= state_nx;
         presc    <= presc_nx;
         lap_reg  <= lap_nx;
         lap_held <= lap_held_nx;
         overflow <= overflow_nx;
         tick     <= tick_nx;
         running  <= (state_nx == RUN);
      end
   end

   assign display = lap_held ? lap_reg : count;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with TICK_DIV=4, DIGITS=2.
module tb_stopwatch_ctrl;

   localparam int unsigned DIV  = 4;
   localparam int unsigned NDIG = 2;
   localparam int          MODN = 100;
   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       start_stop = 1'b0;
   logic       lap = 1'b0;
   logic       clear = 1'b0;
   logic [4*NDIG-1:0] display;
   logic       running;
   logic       lap_held;
   logic       overflow;
   logic       tick;

   int checks = 0;
   int errors = 0;

   stopwatch_ctrl #(.TICK_DIV(DIV), .DIGITS(NDIG)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .start_stop (start_stop),
      .lap        (lap),
      .clear      (clear),
      .display    (display),
      .running    (running),
      .lap_held   (lap_held),
      .overflow   (overflow),
      .tick       (tick)
   );

   always #5 clock = ~clock;

   // Reference model: elapsed counts RUN cycles since the last clear; prescaler
   // phase and count both follow from it arithmetically.
   int m_mode;
   int m_el;
   int m_held;
   int m_snap;

   function automatic int m_count();
      return (m_el / DIV) % MODN;
   endfunction

   function automatic int m_tick();
      return (m_mode == M_RUN && (m_el % DIV) == DIV - 1) ? 1 : 0;
   endfunction

   function automatic int m_ovf();
      return ((m_el / DIV) >= MODN) ? 1 : 0;
   endfunction

   function automatic logic [7:0] bcd(input int v);
      logic [7:0] r;
      r[3:0] = 4'(v % 10);
      r[7:4] = 4'((v / 10) % 10);
      return r;
   endfunction

   task automatic model_reset();
      m_mode = M_IDLE;
      m_el   = 0;
      m_held = 0;
      m_snap = 0;
   endtask

   task automatic model_edge(input logic ss, input logic cl, input logic lp);
      int cur;
      int cnt;
      cur = m_mode;
      cnt = m_count();
      if (cur == M_RUN) m_el++;
      case (cur)
         M_IDLE: if (ss) m_mode = M_RUN;
         M_RUN: begin
            if (ss) m_mode = M_PAUSE;
            else if (!cl && lp) begin
               if (m_held == 0) begin
                  m_snap = cnt;
                  m_held = 1;
               end else begin
                  m_held = 0;
               end
            end
         end
         default: begin
            if (ss) m_mode = M_RUN;
            else if (cl) begin
               m_mode = M_IDLE;
               m_el   = 0;
               m_held = 0;
               m_snap = 0;
            end else if (lp) m_held = 0;
         end
      endcase
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      chk("display",  32'(display),  32'(bcd(m_held != 0 ? m_snap : m_count())));
      chk("running",  32'(running),  32'(m_mode == M_RUN));
      chk("lap_held", 32'(lap_held), 32'(m_held));
      chk("overflow", 32'(overflow), 32'(m_ovf()));
      chk("tick",     32'(tick),     32'(m_tick()));
   endtask

   // One clock: drive pulses, advance model at the edge, end at the falling edge
   task automatic step(input logic ss, input logic cl, input logic lp);
      start_stop = ss;
      clear      = cl;
      lap        = lp;
      @(posedge clock);
      model_edge(ss, cl, lp);
      #1;
      start_stop = 1'b0;
      clear      = 1'b0;
      lap        = 1'b0;
      @(negedge clock);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset_n = 1'b0;
      model_reset();
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   // Idle-step until the model reaches the wanted count/phase (-1 = don't care)
   task automatic run_until(input string name, input int cnt, input int phase);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if ((cnt < 0 || m_count() == cnt) && (phase < 0 || (m_el % DIV) == phase)) begin
            ok = 1'b1;
            break;
         end
         step(1'b0, 1'b0, 1'b0);
         check_model();
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL %s wait expired actual=timeout required=reached", name);
      end
   endtask

   typedef struct {
      logic       ss;
      logic       cl;
      logic       lp;
      logic [7:0] disp;
      logic       run;
      logic       held;
      logic       ovf;
      logic       tk;
   } vec_t;

   vec_t tbl[12];

   initial begin
      logic [7:0] saved;

      tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{1'b1, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[10] = '{1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[11] = '{1'b0, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0};

      model_reset();
      repeat (2) @(negedge clock);
      chk("reset_display",  32'(display),  32'h0);
      chk("reset_running",  32'(running),  32'h0);
      chk("reset_overflow", 32'(overflow), 32'h0);
      chk("reset_tick",     32'(tick),     32'h0);
      reset_n = 1'b1;
      step(1'b0, 1'b1, 1'b1);
      check_model();

      // Directed vectors
      for (int i = 0; i < 12; i++) begin
         step(tbl[i].ss, tbl[i].cl, tbl[i].lp);
         chk($sformatf("vec%0d_display", i),  32'(display),  32'(tbl[i].disp));
         chk($sformatf("vec%0d_running", i),  32'(running),  32'(tbl[i].run));
         chk($sformatf("vec%0d_lap_held", i), 32'(lap_held), 32'(tbl[i].held));
         chk($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(tbl[i].ovf));
         chk($sformatf("vec%0d_tick", i),     32'(tick),     32'(tbl[i].tk));
      end

      // Ten ticks after start
      do_reset();
      step(1'b1, 1'b0, 1'b0);
      check_model();
      for (int i = 0; i < 40; i++) begin
         step(1'b0, 1'b0, 1'b0);
         check_model();
      end
      chk("ten_ticks_display", 32'(display), 32'h10);
      chk("ten_ticks_running", 32'(running), 32'h1);

      // Lap hold at 03 while the live count advances
      do_reset();
      step(1'b1, 1'b0, 1'b0);
      run_until("reach_03", 3, 0);
      step(1'b0, 1'b0, 1'b1);
      check_model();
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b0, 1'b0);
         check_model();
      end
      chk("lap_frozen", 32'(display), 32'h03);
      step(1'b0, 1'b0, 1'b1);
      check_model();
      chk("lap_release", 32'(display), 32'h07);

      // Pause at prescaler 2, resume gives a tick one cycle later
      run_until("phase2", -1, 2);
      step(1'b1, 1'b0, 1'b0);
      check_model();
      saved = display;
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b0, 1'b0);
         check_model();
      end
      chk("pause_hold", 32'(display), 32'(saved));
      step(1'b1, 1'b0, 1'b0);
      chk("resume_tick", 32'(tick), 32'h1);
      check_model();

      // Wrap from 99, clear ignored in RUN, clear from PAUSE
      do_reset();
      step(1'b1, 1'b0, 1'b0);
      run_until("reach_99_tick", 99, DIV - 1);
      chk("pre_wrap_display", 32'(display), 32'h99);
      step(1'b0, 1'b0, 1'b0);
      chk("wrap_display",  32'(display),  32'h00);
      chk("wrap_overflow", 32'(overflow), 32'h1);
      step(1'b0, 1'b1, 1'b0);
      chk("run_clear_running",  32'(running),  32'h1);
      chk("run_clear_overflow", 32'(overflow), 32'h1);
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0);
      chk("clear_display",  32'(display),  32'h00);
      chk("clear_overflow", 32'(overflow), 32'h0);
      chk("clear_running",  32'(running),  32'h0);
      check_model();

      // Lap coincident with tick at 05
      step(1'b1, 1'b0, 1'b0);
      run_until("reach_05_tick", 5, DIV - 1);
      step(1'b0, 1'b0, 1'b1);
      chk("tick_lap_snapshot", 32'(display), 32'h05);
      step(1'b0, 1'b0, 1'b1);
      chk("tick_lap_live", 32'(display), 32'h06);
      check_model();

      // Asynchronous reset between edges
      run_until("reach_08", 8, 0);
      #1;
      reset_n = 1'b0;
      #1;
      chk("areset_display",  32'(display),  32'h0);
      chk("areset_running",  32'(running),  32'h0);
      chk("areset_lap_held", 32'(lap_held), 32'h0);
      chk("areset_overflow", 32'(overflow), 32'h0);
      chk("areset_tick",     32'(tick),     32'h0);
      model_reset();
      @(negedge clock);
      reset_n = 1'b1;
      step(1'b0, 1'b1, 1'b1);
      check_model();
      chk("post_reset_idle", 32'(running), 32'h0);

      // Randomised pulses against the model
      for (int i = 0; i < 3000; i++) begin
         step(1'($urandom_range(0, 15) == 0),
              1'($urandom_range(0, 39) == 0),
              1'($urandom_range(0, 11) == 0));
         check_model();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
